// File: rtl/ins_fetch_sched.sv
// ins_fetch_sched: shares one async SRAM port between instruction prefetch into a FWFT FIFO
// and loader writes. Define INS_FETCH_LOOP_EN to restart at BASE_ADDR on an END word.
module ins_fetch_sched #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic [15:0]       INS_DATA,
  output logic              INS_VALID,
  input  logic              INS_READY,
  output logic              PLAYING,
  output logic              DONE,
  input  logic              WR_REQ,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [15:0]       WR_DATA,
  output logic              WR_ACK,
  output logic [ADDR_W-1:0] SRAM_A,
  output logic [15:0]       SRAM_DQ_O,
  output logic              SRAM_DQ_OE,
  input  logic [15:0]       SRAM_D,
  output logic              SRAM_WE,
  output logic              SRAM_OE
);
  localparam int WC_W  = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam int PTR_W = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int CNT_W = (FIFO_DEPTH < 2) ? 2 : $clog2(FIFO_DEPTH + 1);
  localparam logic [WC_W-1:0]  LAST_WC = WC_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

`ifdef INS_FETCH_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  if (WAIT_CYCLES < 1) begin : gBadWait
    $error("ins_fetch_sched: WAIT_CYCLES must be >= 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
    $error("ins_fetch_sched: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  typedef enum logic [1:0] {IDLE, RD, WR, HALT} stateT;

  stateT             state, stateNext;
  logic [WC_W-1:0]   wcnt;
  logic [ADDR_W-1:0] pc;
  logic              playing, done, halted, haltedNext, discard, prefRead;
  logic              grantRd, grantWr, accessEnd, readOk, wordEnd, rdEnd, push, pop;
  logic [15:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr, rdPtr;
  logic [CNT_W-1:0]  count;

  // Arbitration only runs between accesses, so no read is ever in flight when it is evaluated.
  assign readOk     = playing && !START && (count < DEPTH_C);
  assign wordEnd    = (SRAM_D[15:12] == 4'h0);
  assign rdEnd      = (state == RD) && accessEnd;
  assign push       = rdEnd && !discard && !START && !(wordEnd && LOOP_EN);
  assign pop        = INS_VALID && INS_READY;
  assign haltedNext = START ? 1'b0 : (halted || (rdEnd && !discard && wordEnd && !LOOP_EN));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= stateNext;
      wcnt  <= ((state == RD || state == WR) && !accessEnd) ? wcnt + 1'b1 : '0;
    end
  end

  always_comb begin
    stateNext  = state;
    grantRd    = 1'b0;
    grantWr    = 1'b0;
    accessEnd  = 1'b0;
    SRAM_A     = '0;
    SRAM_OE    = 1'b1;
    SRAM_WE    = 1'b1;
    SRAM_DQ_OE = 1'b0;
    WR_ACK     = 1'b0;
    case (state)
      IDLE, HALT: begin
        // Write wins unless the previous access was a write and a read is also pending.
        if (WR_REQ && !(readOk && prefRead)) grantWr = 1'b1;
        else if (readOk)                     grantRd = 1'b1;
        if (grantWr)      stateNext = WR;
        else if (grantRd) stateNext = RD;
        else              stateNext = haltedNext ? HALT : IDLE;
      end
      RD: begin
        SRAM_A  = pc;
        SRAM_OE = 1'b0;
        if (wcnt == LAST_WC) begin
          accessEnd = 1'b1;
          stateNext = haltedNext ? HALT : IDLE;
        end
      end
      WR: begin
        SRAM_A     = WR_ADDR;
        SRAM_DQ_OE = 1'b1;
        SRAM_WE    = (wcnt == '0);
        if (wcnt == LAST_WC) begin
          WR_ACK    = 1'b1;
          accessEnd = 1'b1;
          stateNext = haltedNext ? HALT : IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc       <= BASE_ADDR;
      playing  <= 1'b0;
      done     <= 1'b0;
      halted   <= 1'b0;
      discard  <= 1'b0;
      prefRead <= 1'b0;
    end else begin
      halted  <= haltedNext;
      discard <= (state == RD) && !accessEnd && (discard || START);
      if (accessEnd)
        prefRead <= (state == WR);
      else if ((state == IDLE || state == HALT) && !grantWr && !grantRd)
        prefRead <= 1'b0;
      if (START) begin
        pc      <= BASE_ADDR;
        playing <= 1'b1;
        done    <= 1'b0;
      end else begin
        if (rdEnd && !discard) begin
          if (wordEnd && LOOP_EN) pc <= BASE_ADDR;
          else                    pc <= pc + 1'b1;
          if (wordEnd && !LOOP_EN) playing <= 1'b0;
        end
        if (pop && INS_DATA[15:12] == 4'h0 && !LOOP_EN) done <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || START) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifoMem[wrPtr] <= SRAM_D;
  end

  assign INS_VALID = (count != '0);
  assign INS_DATA  = INS_VALID ? fifoMem[rdPtr] : 16'h0;
  assign PLAYING   = playing;
  assign DONE      = done;
  assign SRAM_DQ_O = WR_DATA;

endmodule

// File: tb/tb_ins_fetch_sched.sv
// Self-checking bench for ins_fetch_sched: behavioural SRAM, output scoreboard, vector table
// and hand sequences for backpressure, arbitration, restart, PC wrap and reset abort.
`timescale 1ns/1ps
module tb_ins_fetch_sched;
  localparam int AW   = 18;
  localparam int WAIT = 2;
  localparam logic [7:0] AR = 8'h52;
  localparam logic [7:0] AWR = 8'h57;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST, START, INS_READY, WR_REQ;
  logic [AW-1:0] WR_ADDR;
  logic [15:0]   WR_DATA, INS_DATA, SRAM_DQ_O, SRAM_D;
  logic          INS_VALID, PLAYING, DONE, WR_ACK, SRAM_DQ_OE, SRAM_WE, SRAM_OE;
  logic [AW-1:0] SRAM_A;

  logic          START2, READY2;
  logic [15:0]   INS_DATA2, SRAM_DQ_O2, SRAM_D2;
  logic          INS_VALID2, PLAYING2, DONE2, WR_ACK2, SRAM_DQ_OE2, SRAM_WE2, SRAM_OE2;
  logic [AW-1:0] SRAM_A2;
  logic          WR_REQ2 = 1'b0;
  logic [AW-1:0] WR_ADDR2 = '0;
  logic [15:0]   WR_DATA2 = '0;

  ins_fetch_sched #(.ADDR_W(AW), .WAIT_CYCLES(WAIT), .FIFO_DEPTH(4), .BASE_ADDR('0)) dut (
    .CLK(CLK), .RST(RST), .START(START), .INS_DATA(INS_DATA), .INS_VALID(INS_VALID),
    .INS_READY(INS_READY), .PLAYING(PLAYING), .DONE(DONE), .WR_REQ(WR_REQ),
    .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_ACK(WR_ACK), .SRAM_A(SRAM_A),
    .SRAM_DQ_O(SRAM_DQ_O), .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_D(SRAM_D),
    .SRAM_WE(SRAM_WE), .SRAM_OE(SRAM_OE));

  ins_fetch_sched #(.ADDR_W(AW), .WAIT_CYCLES(WAIT), .FIFO_DEPTH(4), .BASE_ADDR(18'h3FFFF)) dutWrap (
    .CLK(CLK), .RST(RST), .START(START2), .INS_DATA(INS_DATA2), .INS_VALID(INS_VALID2),
    .INS_READY(READY2), .PLAYING(PLAYING2), .DONE(DONE2), .WR_REQ(WR_REQ2),
    .WR_ADDR(WR_ADDR2), .WR_DATA(WR_DATA2), .WR_ACK(WR_ACK2), .SRAM_A(SRAM_A2),
    .SRAM_DQ_O(SRAM_DQ_O2), .SRAM_DQ_OE(SRAM_DQ_OE2), .SRAM_D(SRAM_D2),
    .SRAM_WE(SRAM_WE2), .SRAM_OE(SRAM_OE2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Behavioural SRAMs: data presented mid-cycle, writes committed while WE is low.
  logic [15:0] mem  [int];
  logic [15:0] mem2 [int];
  logic [7:0]  accLog [$];
  int          readCnt = 0;
  int          ackCnt = 0;
  logic        prevOe = 1'b1;
  logic        prevDqOe = 1'b0;

  always @(negedge CLK) begin
    if (!SRAM_WE && SRAM_DQ_OE) mem[int'(SRAM_A)] = SRAM_DQ_O;
    if (prevOe && !SRAM_OE) begin
      readCnt++;
      accLog.push_back(AR);
    end
    if (!prevDqOe && SRAM_DQ_OE) accLog.push_back(AWR);
    if (WR_ACK) ackCnt++;
    prevOe   = SRAM_OE;
    prevDqOe = SRAM_DQ_OE;
    if (SRAM_OE) SRAM_D = 16'h0;
    else SRAM_D = mem.exists(int'(SRAM_A)) ? mem[int'(SRAM_A)] : 16'h7777;
    if (SRAM_OE2) SRAM_D2 = 16'h0;
    else SRAM_D2 = mem2.exists(int'(SRAM_A2)) ? mem2[int'(SRAM_A2)] : 16'h7777;
  end

  // Scoreboard: expected words are queued when a program is started, popped on each transfer.
  logic [15:0] expQ [$];
  logic [15:0] gotQ2 [$];
  int          popCnt = 0;
  bit          endPending = 1'b0;

  always @(negedge CLK) begin
    if (endPending) begin
      chk("done_after_end", DONE, 1);
      endPending = 1'b0;
    end
    if (INS_VALID && INS_READY) begin
      popCnt++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%0h required=none", INS_DATA);
      end else begin
        chk("ins_data", INS_DATA, expQ.pop_front());
      end
      $display("pop word=%04h done=%0b", INS_DATA, DONE);
      if (INS_DATA[15:12] == 4'h0) begin
        chk("done_before_end_pop", DONE, 0);
        endPending = 1'b1;
      end
    end
    if (INS_VALID2 && READY2) gotQ2.push_back(INS_DATA2);
  end

  typedef struct packed {
    logic [3:0][15:0] w;
    int               expLen;
    int               expLat;
  } vecT;
  vecT vecs [4];

  task automatic waitDone(input string name);
    int n = 0;
    while (!DONE && n < 300) begin
      tick(1);
      n++;
    end
    chk(name, DONE, 1);
  endtask

  initial begin
    int n, p0, r0, a0, ls, nw;
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p0, r0, a0, ls, nw;
    RST = 1; START = 0; INS_READY = 0; WR_REQ = 0; WR_ADDR = '0; WR_DATA = '0;
    START2 = 0; READY2 = 0;
    tick(3);
    chk("rst_sram_we", SRAM_WE, 1);
    chk("rst_sram_oe", SRAM_OE, 1);
    chk("rst_dq_oe", SRAM_DQ_OE, 0);
    chk("rst_sram_a", SRAM_A, 0);
    chk("rst_ins_valid", INS_VALID, 0);
    chk("rst_ins_data", INS_DATA, 0);
    chk("rst_wr_ack", WR_ACK, 0);
    chk("rst_playing", PLAYING, 0);
    chk("rst_done", DONE, 0);
    RST = 0;
    tick(1);

    vecs[0] = '{w: {16'h4444, 16'h0000, 16'h8245, 16'h8123}, expLen: 3, expLat: WAIT + 3};
    vecs[1] = '{w: {16'h4444, 16'h4444, 16'h0000, 16'h8001}, expLen: 2, expLat: WAIT + 3};
    vecs[2] = '{w: {16'h4444, 16'h4444, 16'h4444, 16'h0000}, expLen: 1, expLat: WAIT + 3};
    vecs[3] = '{w: {16'h0FFF, 16'hA5A5, 16'h1234, 16'hF00F}, expLen: 4, expLat: WAIT + 3};
    for (int t = 0; t < 4; t++) begin
      for (int a = 0; a < 4; a++) mem[a] = vecs[t].w[a];
      for (int a = 0; a < vecs[t].expLen; a++) expQ.push_back(vecs[t].w[a]);
      p0 = popCnt;
      INS_READY = 1; START = 1;
      tick(1);
      START = 0;
      n = 1;
      while (!INS_VALID && n < 50) begin
        tick(1);
        n++;
      end
      chk("first_valid_latency", n, vecs[t].expLat);
      waitDone("vec_done");
      tick(2);
      chk("vec_playing_off", PLAYING, 0);
      chk("vec_words_out", popCnt - p0, vecs[t].expLen);
      chk("vec_queue_empty", expQ.size(), 0);
      $display("vector %0d latency=%0d words=%0d", t, n, popCnt - p0);
    end

    // Backpressure: FIFO fills after exactly FIFO_DEPTH reads; one pop allows one more read.
    for (int a = 0; a < 10; a++) mem[a] = 16'h9000 | 16'(a);
    mem[10] = 16'h0000;
    for (int a = 0; a <= 10; a++) expQ.push_back(mem[a]);
    INS_READY = 0; r0 = readCnt; START = 1;
    tick(1);
    START = 0;
    tick(40);
    chk("reads_until_full", readCnt - r0, 4);
    chk("valid_when_full", INS_VALID, 1);
    chk("oe_idle_when_full", SRAM_OE, 1);
    INS_READY = 1;
    tick(1);
    INS_READY = 0;
    tick(20);
    chk("reads_after_one_pop", readCnt - r0, 5);
    INS_READY = 1;
    waitDone("full_done");
    chk("full_queue_empty", expQ.size(), 0);

    // Continuous write requests while playing: strict WR/RD alternation.
    for (int a = 0; a < 8; a++) mem[a] = 16'hA000 | 16'(a);
    mem[8] = 16'h0000;
    for (int a = 0; a <= 8; a++) expQ.push_back(mem[a]);
    ls = accLog.size(); a0 = ackCnt;
    WR_REQ = 1; WR_ADDR = 18'h200; WR_DATA = 16'hC000; START = 1;
    tick(1);
    START = 0;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (!WR_ACK && n < 50) begin
        tick(1);
        n++;
      end
      chk("wr_ack_seen", WR_ACK, 1);
      $display("write k=%0d addr=%0h data=%04h", k, WR_ADDR, WR_DATA);
      tick(1);
      if (k == 5) WR_REQ = 0;
      WR_ADDR = 18'h200 + 18'(k + 1);
      WR_DATA = 16'hC000 + 16'(k + 1);
    end
    waitDone("alt_done");
    chk("alt_log_len_ok", accLog.size() - ls >= 12, 1);
    if (accLog.size() - ls >= 12)
      for (int i = 0; i < 12; i++) chk("alt_sequence", accLog[ls + i], (i % 2 == 0) ? AWR : AR);
    nw = 0;
    for (int i = ls; i < accLog.size(); i++) if (accLog[i] == AWR) nw++;
    chk("ack_per_write", ackCnt - a0, nw);
    chk("ack_count", ackCnt - a0, 6);
    for (int k = 0; k < 6; k++)
      chk("wr_mem", mem.exists(32'h200 + k) ? 32'(mem[32'h200 + k]) : 32'hFFFF_FFFF, 32'hC000 + k);

    // START while the read at PC=5 is in progress: that word must not appear.
    for (int a = 0; a < 6; a++) mem[a] = 16'hB000 | 16'(a << 4);
    mem[6] = 16'h0000;
    for (int a = 0; a <= 6; a++) expQ.push_back(mem[a]);
    INS_READY = 1; START = 1;
    tick(1);
    START = 0;
    n = 0;
    while (!(SRAM_A == 18'd5 && !SRAM_OE) && n < 100) begin
      tick(1);
      n++;
    end
    chk("reached_pc5_read", {SRAM_OE, 14'd0, SRAM_A}, 32'd5);
    INS_READY = 0; START = 1;
    expQ.delete();
    for (int a = 0; a <= 6; a++) expQ.push_back(mem[a]);
    tick(1);
    START = 0; INS_READY = 1;
    waitDone("restart_done");
    chk("restart_queue_empty", expQ.size(), 0);

    // PC wrap on the BASE_ADDR=top instance.
    mem2[32'h3FFFF] = 16'h8001;
    mem2[0] = 16'h0000;
    mem2[1] = 16'h4444;
    READY2 = 1; START2 = 1;
    tick(1);
    START2 = 0;
    n = 0;
    while (!DONE2 && n < 100) begin
      tick(1);
      n++;
    end
    chk("wrap_done", DONE2, 1);
    chk("wrap_word_count", gotQ2.size(), 2);
    if (gotQ2.size() >= 2) begin
      chk("wrap_word0", gotQ2[0], 16'h8001);
      chk("wrap_word1", gotQ2[1], 16'h0000);
    end
    $display("wrap words=%0d", gotQ2.size());

    // Reset during write cycle 1 aborts the access.
    WR_REQ = 1; WR_ADDR = 18'h300; WR_DATA = 16'h5A5A;
    n = 0;
    while (!SRAM_DQ_OE && n < 20) begin
      tick(1);
      n++;
    end
    chk("wr_cycle0_we", {SRAM_DQ_OE, SRAM_WE}, 2'b11);
    tick(1);
    chk("wr_cycle1_we", SRAM_WE, 0);
    RST = 1;
    tick(1);
    WR_REQ = 0;
    chk("rst_abort_we", SRAM_WE, 1);
    chk("rst_abort_ack", WR_ACK, 0);
    chk("rst_abort_dq_oe", SRAM_DQ_OE, 0);
    chk("rst_abort_oe", SRAM_OE, 1);
    RST = 0;
    tick(2);
    chk("rst_idle_addr", SRAM_A, 0);
    chk("rst_idle_done", DONE, 0);
    chk("rst_idle_playing", PLAYING, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
